exu_flush_req: RTL and testbench
================================

Name: exu_flush_req

Overview:
- Execute-stage flush request generator, directly upstream of the flush-stall tracker.
- Collects redirect events (taken branch, JALR, trap) from the execute unit and classifies each as a single-cycle or double-cycle flush.
- Drives the 2-bit flush code to the tracker, holding it until the sample phase (cycle_cnt == SAMPLE_PHASE); then issues a one-cycle redirect to fetch.
- Buffers one follow-on request while a request is outstanding.

Parameters:
- XLEN, 32, width of target/redirect addresses
- CNT_W, 4, width of cycle_cnt
- SAMPLE_PHASE, 4, cycle_cnt value at which the downstream tracker samples flush

Ports:
- hclk  input  1  clock
- hrstn  input  1  asynchronous active-low reset
- cycle_cnt  input  CNT_W  pipeline phase counter, shared with tracker
- flush_stall  input  1  stall output of downstream tracker
- br_taken  input  1  taken/mispredicted branch resolved this cycle
- br_target  input  XLEN  branch target
- jalr_valid  input  1  JALR resolved this cycle
- jalr_target  input  XLEN  JALR target (bit 0 already cleared)
- trap_valid  input  1  trap/exception taken this cycle
- trap_vec  input  XLEN  trap vector address
- flush  output  2  0 = none, 1 = FLUSH_CYCLE_1, 2 = FLUSH_CYCLE_2 (3 never driven)
- redirect_valid  output  1  one-cycle fetch redirect pulse
- redirect_pc  output  XLEN  redirect target, valid with redirect_valid
- pend_overflow  output  1  sticky: request lost because the pending slot was full

Behaviour:
- Reset (async, hrstn low): state = IDLE; flush = 0; redirect_valid = 0; redirect_pc = 0; pending slot empty; pend_overflow = 0. Reset asserted mid-request discards all held and pending requests immediately.
- Classification:
  - branch -> FLUSH_CYCLE_1
  - JALR -> FLUSH_CYCLE_2
  - trap -> FLUSH_CYCLE_2
- Event priority when simultaneous: trap > jalr > branch. Only the winner is captured; the losers are dropped silently.
- Event gating while flush_stall == 1: branch/jalr are wrong-path and are ignored; trap is always accepted.
- FSM states: IDLE, ARMED, ISSUE.
- IDLE:
  - accepted event -> latch code and target, go to ARMED next clock.
  - flush stays 0 in IDLE.
- ARMED:
  - flush is driven registered from the latched code.
  - In the cycle where cycle_cnt == SAMPLE_PHASE, the consumer has sampled; go to ISSUE next clock.
  - Event arrival in ARMED (gated as above):
    - pending slot empty -> store the event there.
    - pending slot full -> a higher-priority event replaces the stored one; otherwise the event is dropped. Either way pend_overflow sets.
  - An event arriving in the same cycle as the sample phase goes to the pending slot.
- ISSUE (exactly one cycle):
  - flush = 0; redirect_valid = 1; redirect_pc = latched target.
  - pending slot full -> move it to active, go to ARMED.
  - otherwise -> IDLE.
  - A new event arriving in ISSUE behaves as in IDLE if the pending slot is empty, otherwise as in ARMED.
- Latency (event in cycle t, idle): flush valid from t+1; redirect_valid in the cycle after the first sample phase at or after t+1.
- An event in the sample-phase cycle itself waits one full phase period.
- cycle_cnt wrap is opaque: only equality with SAMPLE_PHASE matters.
- pend_overflow clears only on reset.

Optional Feature:
- Macro: FLUSH_PERF_CNT_EN.
- Defined:
  - adds outputs perf_flush1_cnt[31:0] and perf_flush2_cnt[31:0].
  - The matching counter increments on each ISSUE cycle by the issued code; saturates at 0xFFFFFFFF.
  - Counters are async-reset to 0.
- Undefined: ports and counters absent; all other behaviour identical.

Decomposition:
- Shared package exu_flush_pkg:
  - flush code constants FLUSH_DISABLE/FLUSH_CYCLE_1/FLUSH_CYCLE_2
  - FSM state encodings IDLE/ARMED/ISSUE
  - SAMPLE_PHASE default
- The tracker imports the same codes.
- Sub-module exu_flush_arb: combinational priority select, stall gating and classification; returns valid, code, target.

Test Plan:
- Reset, cycle_cnt free-running 0..15, br_taken at cycle_cnt=1 with br_target=0x100 -> flush=1 from next cycle until the cycle_cnt=4 cycle; next cycle redirect_valid=1, redirect_pc=0x100; then flush=0, IDLE.
- trap_valid, jalr_valid and br_taken in the same cycle, trap_vec=0x80 -> flush=2, redirect_pc=0x80 only; exactly one redirect pulse.
- JALR (target 0x200) armed, then branch at a non-sample phase (target 0x300) -> second redirect 0x300 issued via ARMED one phase period after the first; pend_overflow=0.
- Two more branches while ARMED with the slot already full -> pend_overflow=1 and stays 1; trap while the slot holds a branch replaces it.
- flush_stall=1 with br_taken -> ignored (flush stays 0); trap_valid with flush_stall=1 -> accepted, flush=2.
- hrstn dropped while ARMED with the pending slot full -> all outputs 0 immediately; after release, no stale redirect occurs. With FLUSH_PERF_CNT_EN, counters read 0.

Source files
------------

// File: rtl/exu_flush_pkg.sv
// Shared flush codes, FSM states and event priorities for the execute-stage flush path.
// The flush-stall tracker imports the same flush codes.
package exu_flush_pkg;

    localparam int unsigned SAMPLE_PHASE_DEF = 4;

    typedef enum logic [1:0] {
        FLUSH_DISABLE = 2'd0,
        FLUSH_CYCLE_1 = 2'd1,
        FLUSH_CYCLE_2 = 2'd2
    } flush_code_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        ISSUE = 2'd2
    } flush_state_e;

    // Trap and JALR share a flush code, so the pending slot keeps an explicit rank.
    typedef enum logic [1:0] {
        PRIO_NONE = 2'd0,
        PRIO_BR   = 2'd1,
        PRIO_JALR = 2'd2,
        PRIO_TRAP = 2'd3
    } ev_prio_e;

endpackage

// File: rtl/exu_flush_arb.sv
// Redirect event arbiter: trap > jalr > branch, with wrong-path gating under flush_stall.
module exu_flush_arb
    import exu_flush_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic              flush_stall,
    input  logic              br_taken,
    input  logic [XLEN-1:0]   br_target,
    input  logic              jalr_valid,
    input  logic [XLEN-1:0]   jalr_target,
    input  logic              trap_valid,
    input  logic [XLEN-1:0]   trap_vec,
    output logic              ev_valid,
    output flush_code_e       ev_code,
    output logic [XLEN-1:0]   ev_target,
    output ev_prio_e          ev_prio
);

    always_comb begin
        ev_valid  = 1'b0;
        ev_code   = FLUSH_DISABLE;
        ev_target = '0;
        ev_prio   = PRIO_NONE;
        if (trap_valid) begin
            ev_valid  = 1'b1;
            ev_code   = FLUSH_CYCLE_2;
            ev_target = trap_vec;
            ev_prio   = PRIO_TRAP;
        end else if (jalr_valid && !flush_stall) begin
            ev_valid  = 1'b1;
            ev_code   = FLUSH_CYCLE_2;
            ev_target = jalr_target;
            ev_prio   = PRIO_JALR;
        end else if (br_taken && !flush_stall) begin
            ev_valid  = 1'b1;
            ev_code   = FLUSH_CYCLE_1;
            ev_target = br_target;
            ev_prio   = PRIO_BR;
        end
    end

endmodule

// File: rtl/exu_flush_req.sv
// Execute-stage flush request generator: holds the flush code until the sample phase, then redirects fetch.
// Optional FLUSH_PERF_CNT_EN adds saturating per-code issue counters.
module exu_flush_req
    import exu_flush_pkg::*;
#(
    parameter int unsigned XLEN         = 32,
    parameter int unsigned CNT_W        = 4,
    parameter int unsigned SAMPLE_PHASE = SAMPLE_PHASE_DEF
) (
    input  logic              hclk,
    input  logic              hrstn,
    input  logic [CNT_W-1:0]  cycle_cnt,
    input  logic              flush_stall,
    input  logic              br_taken,
    input  logic [XLEN-1:0]   br_target,
    input  logic              jalr_valid,
    input  logic [XLEN-1:0]   jalr_target,
    input  logic              trap_valid,
    input  logic [XLEN-1:0]   trap_vec,
    output logic [1:0]        flush,
    output logic              redirect_valid,
    output logic [XLEN-1:0]   redirect_pc,
    output logic              pend_overflow
`ifdef FLUSH_PERF_CNT_EN
    ,
    output logic [31:0]       perf_flush1_cnt,
    output logic [31:0]       perf_flush2_cnt
`endif
);

    localparam logic [CNT_W-1:0] SAMPLE_CNT = CNT_W'(SAMPLE_PHASE);

    logic            ev_valid;
    flush_code_e     ev_code;
    logic [XLEN-1:0] ev_target;
    ev_prio_e        ev_prio;

    flush_state_e    state_q, state_d;
    flush_code_e     act_code_q, act_code_d;
    logic [XLEN-1:0] act_tgt_q, act_tgt_d;
    logic            pend_vld_q, pend_vld_d;
    flush_code_e     pend_code_q, pend_code_d;
    logic [XLEN-1:0] pend_tgt_q, pend_tgt_d;
    ev_prio_e        pend_prio_q, pend_prio_d;
    flush_code_e     flush_q, flush_d;
    logic            rv_q, rv_d;
    logic [XLEN-1:0] rpc_q, rpc_d;
    logic            ovf_q, ovf_d;
    logic            sample;

    exu_flush_arb #(.XLEN(XLEN)) u_arb (
        .flush_stall (flush_stall),
        .br_taken    (br_taken),
        .br_target   (br_target),
        .jalr_valid  (jalr_valid),
        .jalr_target (jalr_target),
        .trap_valid  (trap_valid),
        .trap_vec    (trap_vec),
        .ev_valid    (ev_valid),
        .ev_code     (ev_code),
        .ev_target   (ev_target),
        .ev_prio     (ev_prio)
    );

    assign sample = (cycle_cnt == SAMPLE_CNT);

    always_comb begin
        state_d     = state_q;
        act_code_d  = act_code_q;
        act_tgt_d   = act_tgt_q;
        pend_vld_d  = pend_vld_q;
        pend_code_d = pend_code_q;
        pend_tgt_d  = pend_tgt_q;
        pend_prio_d = pend_prio_q;
        flush_d     = FLUSH_DISABLE;
        rv_d        = 1'b0;
        rpc_d       = rpc_q;
        ovf_d       = ovf_q;
        unique case (state_q)
            IDLE: begin
                if (ev_valid) begin
                    act_code_d = ev_code;
                    act_tgt_d  = ev_target;
                    flush_d    = ev_code;
                    state_d    = ARMED;
                end
            end
            ARMED: begin
                flush_d = act_code_q;
                if (ev_valid) begin
                    if (!pend_vld_q || ev_prio > pend_prio_q) begin
                        pend_vld_d  = 1'b1;
                        pend_code_d = ev_code;
                        pend_tgt_d  = ev_target;
                        pend_prio_d = ev_prio;
                    end
                    if (pend_vld_q)
                        ovf_d = 1'b1;
                end
                if (sample) begin
                    flush_d = FLUSH_DISABLE;
                    rv_d    = 1'b1;
                    rpc_d   = act_tgt_q;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                // Full slot: a newly arriving higher-rank event overrides it on promotion to active.
                if (pend_vld_q) begin
                    if (ev_valid && ev_prio > pend_prio_q) begin
                        act_code_d = ev_code;
                        act_tgt_d  = ev_target;
                    end else begin
                        act_code_d = pend_code_q;
                        act_tgt_d  = pend_tgt_q;
                    end
                    if (ev_valid)
                        ovf_d = 1'b1;
                    pend_vld_d  = 1'b0;
                    pend_prio_d = PRIO_NONE;
                    flush_d     = (ev_valid && ev_prio > pend_prio_q) ? ev_code : pend_code_q;
                    state_d     = ARMED;
                end else if (ev_valid) begin
                    act_code_d = ev_code;
                    act_tgt_d  = ev_target;
                    flush_d    = ev_code;
                    state_d    = ARMED;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge hclk or negedge hrstn) begin
        if (!hrstn) begin
            state_q     <= IDLE;
            act_code_q  <= FLUSH_DISABLE;
            act_tgt_q   <= '0;
            pend_vld_q  <= 1'b0;
            pend_code_q <= FLUSH_DISABLE;
            pend_tgt_q  <= '0;
            pend_prio_q <= PRIO_NONE;
            flush_q     <= FLUSH_DISABLE;
            rv_q        <= 1'b0;
            rpc_q       <= '0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            act_code_q  <= act_code_d;
            act_tgt_q   <= act_tgt_d;
            pend_vld_q  <= pend_vld_d;
            pend_code_q <= pend_code_d;
            pend_tgt_q  <= pend_tgt_d;
            pend_prio_q <= pend_prio_d;
            flush_q     <= flush_d;
            rv_q        <= rv_d;
            rpc_q       <= rpc_d;
            ovf_q       <= ovf_d;
        end
    end

    assign flush          = flush_q;
    assign redirect_valid = rv_q;
    assign redirect_pc    = rpc_q;
    assign pend_overflow  = ovf_q;

`ifdef FLUSH_PERF_CNT_EN
    always_ff @(posedge hclk or negedge hrstn) begin
        if (!hrstn) begin
            perf_flush1_cnt <= '0;
            perf_flush2_cnt <= '0;
        end else if (state_q == ISSUE) begin
            if (act_code_q == FLUSH_CYCLE_1 && perf_flush1_cnt != '1)
                perf_flush1_cnt <= perf_flush1_cnt + 32'd1;
            if (act_code_q == FLUSH_CYCLE_2 && perf_flush2_cnt != '1)
                perf_flush2_cnt <= perf_flush2_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_exu_flush_req.sv
// Directed bench for exu_flush_req; build with FLUSH_PERF_CNT_EN to also check the issue counters.
module tb_exu_flush_req;

    logic        hclk;
    logic        hrstn;
    logic [3:0]  cycle_cnt;
    logic        flush_stall;
    logic        br_taken;
    logic [31:0] br_target;
    logic        jalr_valid;
    logic [31:0] jalr_target;
    logic        trap_valid;
    logic [31:0] trap_vec;
    logic [1:0]  flush;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        pend_overflow;
`ifdef FLUSH_PERF_CNT_EN
    logic [31:0] perf_flush1_cnt;
    logic [31:0] perf_flush2_cnt;
`endif

    int vectors;
    int miscompares;
    int pulses;
    logic [31:0] seen_pc;

    exu_flush_req #(.XLEN(32), .CNT_W(4), .SAMPLE_PHASE(4)) dut (
        .hclk           (hclk),
        .hrstn          (hrstn),
        .cycle_cnt      (cycle_cnt),
        .flush_stall    (flush_stall),
        .br_taken       (br_taken),
        .br_target      (br_target),
        .jalr_valid     (jalr_valid),
        .jalr_target    (jalr_target),
        .trap_valid     (trap_valid),
        .trap_vec       (trap_vec),
        .flush          (flush),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .pend_overflow  (pend_overflow)
`ifdef FLUSH_PERF_CNT_EN
        ,
        .perf_flush1_cnt(perf_flush1_cnt),
        .perf_flush2_cnt(perf_flush2_cnt)
`endif
    );

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    // Advance one clock; inputs and cycle_cnt change 1ns after the edge.
    task automatic tick();
        @(posedge hclk);
        #1;
        cycle_cnt = cycle_cnt + 4'd1;
    endtask

    task automatic wait_cnt(input logic [3:0] v);
        do tick(); while (cycle_cnt != v);
    endtask

    task automatic clr_ev();
        flush_stall = 1'b0;
        br_taken    = 1'b0;
        jalr_valid  = 1'b0;
        trap_valid  = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        hrstn = 1'b0;
        cycle_cnt = 4'd0;
        br_target = '0;
        jalr_target = '0;
        trap_vec = '0;
        clr_ev();

        // Reset state
        repeat (2) @(posedge hclk);
        #1;
        chk("rst_flush", 32'(flush), 32'd0);
        chk("rst_rv", 32'(redirect_valid), 32'd0);
        chk("rst_rpc", redirect_pc, 32'd0);
        chk("rst_ovf", 32'(pend_overflow), 32'd0);
        hrstn = 1'b1;
        cycle_cnt = 4'd0;

        // Branch at cnt=1
        wait_cnt(4'd1);
        br_taken = 1'b1; br_target = 32'h100;
        tick(); clr_ev();                               // cnt=2
        chk("br_flush_t1", 32'(flush), 32'd1);
        chk("br_rv_t1", 32'(redirect_valid), 32'd0);
        tick();                                         // cnt=3
        chk("br_flush_t2", 32'(flush), 32'd1);
        tick();                                         // cnt=4
        chk("br_flush_sample", 32'(flush), 32'd1);
        tick();                                         // cnt=5, ISSUE
        chk("br_issue_flush", 32'(flush), 32'd0);
        chk("br_issue_rv", 32'(redirect_valid), 32'd1);
        chk("br_issue_pc", redirect_pc, 32'h100);
        tick();                                         // cnt=6, IDLE
        chk("br_idle_rv", 32'(redirect_valid), 32'd0);
        chk("br_idle_flush", 32'(flush), 32'd0);

        // Simultaneous trap/jalr/branch: trap wins alone
        trap_valid = 1'b1; trap_vec = 32'h80;
        jalr_valid = 1'b1; jalr_target = 32'h200;
        br_taken = 1'b1;   br_target = 32'h300;
        tick(); clr_ev();                               // cnt=7
        chk("pri_flush", 32'(flush), 32'd2);
        pulses = 0;
        seen_pc = '0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (redirect_valid) begin
                pulses++;
                seen_pc = redirect_pc;
            end
        end                                             // cnt=11
        chk("pri_pulses", 32'(pulses), 32'd1);
        chk("pri_pc", seen_pc, 32'h80);
        chk("pri_ovf", 32'(pend_overflow), 32'd0);

        // JALR armed, branch into pending slot
        jalr_valid = 1'b1; jalr_target = 32'h200;
        tick(); clr_ev();                               // cnt=12
        chk("jalr_flush", 32'(flush), 32'd2);
        br_taken = 1'b1; br_target = 32'h300;
        tick(); clr_ev();                               // cnt=13
        wait_cnt(4'd5);
        chk("jalr_rv", 32'(redirect_valid), 32'd1);
        chk("jalr_pc", redirect_pc, 32'h200);
        tick();                                         // cnt=6
        chk("pend_flush", 32'(flush), 32'd1);
        chk("pend_rv_off", 32'(redirect_valid), 32'd0);
        wait_cnt(4'd5);
        chk("pend_rv", 32'(redirect_valid), 32'd1);
        chk("pend_pc", redirect_pc, 32'h300);
        chk("pend_ovf0", 32'(pend_overflow), 32'd0);
        tick();                                         // cnt=6

        // Overflow and trap replacement of a pending branch
        jalr_valid = 1'b1; jalr_target = 32'h400;
        tick(); clr_ev();                               // cnt=7
        br_taken = 1'b1; br_target = 32'h500;
        tick(); clr_ev();                               // cnt=8
        br_taken = 1'b1; br_target = 32'h600;
        tick(); clr_ev();                               // cnt=9
        chk("ovf_set", 32'(pend_overflow), 32'd1);
        br_taken = 1'b1; br_target = 32'h700;
        tick(); clr_ev();                               // cnt=10
        chk("ovf_hold", 32'(pend_overflow), 32'd1);
        trap_valid = 1'b1; trap_vec = 32'h800;
        tick(); clr_ev();                               // cnt=11
        wait_cnt(4'd5);
        chk("ovf_first_pc", redirect_pc, 32'h400);
        tick();                                         // cnt=6
        chk("repl_flush", 32'(flush), 32'd2);
        wait_cnt(4'd5);
        chk("repl_rv", 32'(redirect_valid), 32'd1);
        chk("repl_pc", redirect_pc, 32'h800);
        tick();                                         // cnt=6
        chk("ovf_sticky", 32'(pend_overflow), 32'd1);
        chk("repl_idle", 32'(flush), 32'd0);

        // Stall gating
        flush_stall = 1'b1;
        br_taken = 1'b1; br_target = 32'h900;
        jalr_valid = 1'b1; jalr_target = 32'h940;
        tick(); clr_ev();                               // cnt=7
        chk("stall_ign", 32'(flush), 32'd0);
        tick();                                         // cnt=8
        chk("stall_ign2", 32'(flush), 32'd0);
        flush_stall = 1'b1;
        trap_valid = 1'b1; trap_vec = 32'hA00;
        tick(); clr_ev();                               // cnt=9
        chk("stall_trap", 32'(flush), 32'd2);
        wait_cnt(4'd5);
        chk("stall_trap_pc", redirect_pc, 32'hA00);
        tick();                                         // cnt=6

        // Event in the sample-phase cycle waits a full period
        wait_cnt(4'd4);
        br_taken = 1'b1; br_target = 32'hB00;
        tick(); clr_ev();                               // cnt=5
        chk("sph_flush", 32'(flush), 32'd1);
        chk("sph_no_rv", 32'(redirect_valid), 32'd0);
        wait_cnt(4'd5);
        chk("sph_rv", 32'(redirect_valid), 32'd1);
        chk("sph_pc", redirect_pc, 32'hB00);
        tick();                                         // cnt=6

`ifdef FLUSH_PERF_CNT_EN
        chk("perf1", perf_flush1_cnt, 32'd3);
        chk("perf2", perf_flush2_cnt, 32'd5);
`endif

        // Reset while ARMED with the slot full
        jalr_valid = 1'b1; jalr_target = 32'hC00;
        tick(); clr_ev();                               // cnt=7
        br_taken = 1'b1; br_target = 32'hD00;
        tick(); clr_ev();                               // cnt=8
        br_taken = 1'b1; br_target = 32'hE00;
        tick(); clr_ev();                               // cnt=9
        chk("prerst_flush", 32'(flush), 32'd2);
        hrstn = 1'b0;
        #1;
        chk("arst_flush", 32'(flush), 32'd0);
        chk("arst_rv", 32'(redirect_valid), 32'd0);
        chk("arst_rpc", redirect_pc, 32'd0);
        chk("arst_ovf", 32'(pend_overflow), 32'd0);
`ifdef FLUSH_PERF_CNT_EN
        chk("arst_perf1", perf_flush1_cnt, 32'd0);
        chk("arst_perf2", perf_flush2_cnt, 32'd0);
`endif
        tick();
        hrstn = 1'b1;
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (redirect_valid || flush != 2'd0)
                pulses++;
        end
        chk("no_stale", 32'(pulses), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
